// File: rtl/regfile_sequencer.sv
// Register-transfer sequencer driving the registerfile strobes and selects.
// Define REGSEQ_PIPELINE_EN to accept a new op during EXEC (zero bubbles).
module regfile_sequencer #(
    parameter int unsigned ALU_SETUP = 1
) (
    input  logic        CLK,
    input  logic        RST_bar,
    input  logic [11:0] INSTR,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    output logic        DONE,
    output logic        ILLEGAL,
    output logic        ALU_OE,
    output logic        MAIN_ASSERT_bar,
    output logic        MAIN_LOAD_bar,
    output logic        LHS_ASSERT_bar,
    output logic        RHS_ASSERT_bar,
    output logic        ADDR_ASSERT_bar,
    output logic        ADDR_LOAD_bar,
    output logic        ADDR_INC,
    output logic [2:0]  MAIN_ASSERT_SEL,
    output logic [2:0]  MAIN_LOAD_SEL,
    output logic [2:0]  LHS_ASSERT_SEL,
    output logic [2:0]  RHS_ASSERT_SEL,
    output logic [2:0]  ADDR_ASSERT_SEL,
    output logic [2:0]  ADDR_LOAD_SEL,
    output logic [2:0]  ADDR_INC_SEL
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;

    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_ALU  = 3'd2;
    localparam logic [2:0] OP_AINC = 3'd3;
    localparam logic [2:0] OP_AMOV = 3'd4;

    localparam logic [3:0] SETUP_LAST = 4'(ALU_SETUP - 1);

    logic [1:0]  state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [11:0] instr_q, cur;
    logic        accept;
    logic [2:0]  op, dst, srca, srcb;

    logic ready_n, done_n, ill_n, oe_n, inc_n;
    logic mab_n, mlb_n, lab_n, rab_n, aab_n, alb_n;
    logic [2:0] mas_n, mls_n, las_n, ras_n, aas_n, als_n, ais_n;

    assign accept = INSTR_VALID & INSTR_READY;
    assign cur    = accept ? INSTR : instr_q;
    assign op     = cur[11:9];
    assign dst    = cur[8:6];
    assign srca   = cur[5:3];
    assign srcb   = cur[2:0];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            SETUP: begin
                if (cnt == 4'd0) state_n = EXEC;
                else             cnt_n   = cnt - 4'd1;
            end
            IDLE, EXEC: begin
                // EXEC only sees accept when pipelining is enabled
                if (accept) begin
                    state_n = (op == OP_ALU) ? SETUP : EXEC;
                    cnt_n   = SETUP_LAST;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        mab_n  = 1'b1;
        mlb_n  = 1'b1;
        lab_n  = 1'b1;
        rab_n  = 1'b1;
        aab_n  = 1'b1;
        alb_n  = 1'b1;
        inc_n  = 1'b0;
        oe_n   = 1'b0;
        done_n = 1'b0;
        ill_n  = ILLEGAL;
        mas_n  = MAIN_ASSERT_SEL;
        mls_n  = MAIN_LOAD_SEL;
        las_n  = LHS_ASSERT_SEL;
        ras_n  = RHS_ASSERT_SEL;
        aas_n  = ADDR_ASSERT_SEL;
        als_n  = ADDR_LOAD_SEL;
        ais_n  = ADDR_INC_SEL;
        if (state_n == SETUP) begin
            lab_n = 1'b0;
            rab_n = 1'b0;
            las_n = srca;
            ras_n = srcb;
        end
        if (state_n == EXEC) begin
            done_n = 1'b1;
            case (op)
                OP_MOV: begin
                    mab_n = 1'b0;
                    mlb_n = 1'b0;
                    mas_n = srca;
                    mls_n = dst;
                end
                OP_ALU: begin
                    lab_n = 1'b0;
                    rab_n = 1'b0;
                    las_n = srca;
                    ras_n = srcb;
                    oe_n  = 1'b1;
                    mlb_n = 1'b0;
                    mls_n = dst;
                end
                OP_AINC: begin
                    inc_n = 1'b1;
                    ais_n = dst;
                end
                OP_AMOV: begin
                    aab_n = 1'b0;
                    alb_n = 1'b0;
                    aas_n = srca;
                    als_n = dst;
                end
                default: begin
                    if (op > OP_AMOV) ill_n = 1'b1;
                end
            endcase
        end
    end

`ifdef REGSEQ_PIPELINE_EN
    assign ready_n = (state_n == IDLE) || (state_n == EXEC);
`else
    assign ready_n = (state_n == IDLE);
`endif

    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            instr_q         <= 12'd0;
            INSTR_READY     <= 1'b0;
            DONE            <= 1'b0;
            ILLEGAL         <= 1'b0;
            ALU_OE          <= 1'b0;
            MAIN_ASSERT_bar <= 1'b1;
            MAIN_LOAD_bar   <= 1'b1;
            LHS_ASSERT_bar  <= 1'b1;
            RHS_ASSERT_bar  <= 1'b1;
            ADDR_ASSERT_bar <= 1'b1;
            ADDR_LOAD_bar   <= 1'b1;
            ADDR_INC        <= 1'b0;
            MAIN_ASSERT_SEL <= 3'd0;
            MAIN_LOAD_SEL   <= 3'd0;
            LHS_ASSERT_SEL  <= 3'd0;
            RHS_ASSERT_SEL  <= 3'd0;
            ADDR_ASSERT_SEL <= 3'd0;
            ADDR_LOAD_SEL   <= 3'd0;
            ADDR_INC_SEL    <= 3'd0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            instr_q         <= cur;
            INSTR_READY     <= ready_n;
            DONE            <= done_n;
            ILLEGAL         <= ill_n;
            ALU_OE          <= oe_n;
            MAIN_ASSERT_bar <= mab_n;
            MAIN_LOAD_bar   <= mlb_n;
            LHS_ASSERT_bar  <= lab_n;
            RHS_ASSERT_bar  <= rab_n;
            ADDR_ASSERT_bar <= aab_n;
            ADDR_LOAD_bar   <= alb_n;
            ADDR_INC        <= inc_n;
            MAIN_ASSERT_SEL <= mas_n;
            MAIN_LOAD_SEL   <= mls_n;
            LHS_ASSERT_SEL  <= las_n;
            RHS_ASSERT_SEL  <= ras_n;
            ADDR_ASSERT_SEL <= aas_n;
            ADDR_LOAD_SEL   <= als_n;
            ADDR_INC_SEL    <= ais_n;
        end
    end

endmodule
